// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the shift register chain.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

endpackage

// File: rtl/shift_reg_stage.sv
// One chain stage: data+valid register loading either the previous stage or the input word.
module shift_reg_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en_i,
  input  logic             sel_in_i,
  input  logic             prev_valid_i,
  input  logic [WIDTH-1:0] prev_data_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Next value: hold unless loading, then pick input word or upstream stage.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ld_en_i) begin
      valid_d = sel_in_i ? in_valid_i : prev_valid_i;
      data_d  = sel_in_i ? data_in_i : prev_data_i;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/shift_reg_chain.sv
// Multi-stage shift register with hold/shift/rotate/fill modes, tap mux and occupancy count.
module shift_reg_chain
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAPW  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [TAPW-1:0]            tap_sel,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           tap_out,
  output logic                       tap_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic             arm_d, arm_q;
  logic [1:0]       eff_mode;
  logic             ld_en, sel_first, sel_rest;
  logic [CNTW-1:0]  count_d, count_q;
  logic             full_d, full_q, empty_d, empty_q;
  logic             stage_valid [DEPTH];
  logic [WIDTH-1:0] stage_data  [DEPTH];

  // Stage control; an unarmed chain behaves as HOLD so the first post-reset cycle is ignored.
  always_comb begin
    eff_mode  = arm_q ? mode : MODE_HOLD;
    ld_en     = 1'b0;
    sel_first = 1'b0;
    sel_rest  = 1'b0;
    unique case (eff_mode)
      MODE_HOLD:   ld_en = 1'b0;
      MODE_SHIFT:  begin ld_en = 1'b1; sel_first = 1'b1; end
      MODE_ROTATE: ld_en = 1'b1;
      MODE_FILL:   begin ld_en = 1'b1; sel_first = 1'b1; sel_rest = 1'b1; end
      default:     ld_en = 1'b0;
    endcase
  end

  // Stage 0 takes the last stage as its upstream so ROTATE closes the ring.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam int unsigned Prev = (i == 0) ? DEPTH - 1 : i - 1;
    shift_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .ld_en_i      (ld_en),
      .sel_in_i     ((i == 0) ? sel_first : sel_rest),
      .prev_valid_i (stage_valid[Prev]),
      .prev_data_i  (stage_data[Prev]),
      .in_valid_i   (in_valid),
      .data_in_i    (data_in),
      .valid_o      (stage_valid[i]),
      .data_o       (stage_data[i])
    );
  end

  // Occupancy: one in / one out on SHIFT, unchanged on ROTATE, all-or-nothing on FILL.
  always_comb begin
    arm_d   = 1'b1;
    count_d = count_q;
    unique case (eff_mode)
      MODE_SHIFT: count_d = count_q + CNTW'(in_valid) - CNTW'(stage_valid[DEPTH-1]);
      MODE_FILL:  count_d = in_valid ? CNTW'(DEPTH) : '0;
      default:    count_d = count_q;
    endcase
    full_d  = (count_d == CNTW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Arm flag, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      arm_q   <= arm_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Tap mux; out-of-range selects (non-power-of-2 DEPTH) read as zero.
  always_comb begin
    tap_out   = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAPW'(i)) begin
        tap_out   = stage_data[i];
        tap_valid = stage_valid[i];
      end
    end
  end

  assign data_out  = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_shift_reg_chain.sv
// Randomised + directed bench for shift_reg_chain at DEPTH=8 and DEPTH=6 against an array model.
module tb_shift_reg_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [2:0]  tap_sel = '0;

  logic [31:0] d8_out, d8_tap, d6_out, d6_tap;
  logic        d8_ov, d8_tv, d8_full, d8_empty;
  logic        d6_ov, d6_tv, d6_full, d6_empty;
  logic [3:0]  d8_cnt;
  logic [2:0]  d6_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shift_reg_chain #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .data_in(data_in),
    .tap_sel(tap_sel), .data_out(d8_out), .out_valid(d8_ov), .tap_out(d8_tap),
    .tap_valid(d8_tv), .count(d8_cnt), .full(d8_full), .empty(d8_empty)
  );

  shift_reg_chain #(.WIDTH(32), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .data_in(data_in),
    .tap_sel(tap_sel), .data_out(d6_out), .out_valid(d6_ov), .tap_out(d6_tap),
    .tap_valid(d6_tv), .count(d6_cnt), .full(d6_full), .empty(d6_empty)
  );

  // Reference model: index 0 models DEPTH=8, index 1 models DEPTH=6.
  int unsigned depth_m [2] = '{8, 6};
  logic [31:0] m_data  [2][8];
  bit          m_valid [2][8];
  bit          m_arm   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(int k, bit r, logic [1:0] md, bit iv, logic [31:0] d);
    int n = int'(depth_m[k]);
    logic [31:0] last_d;
    bit          last_v;
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_data[k][i] = '0; m_valid[k][i] = 0; end
      m_arm[k] = 0;
      return;
    end
    if (!m_arm[k]) begin
      m_arm[k] = 1;
      return;
    end
    last_d = m_data[k][n-1];
    last_v = m_valid[k][n-1];
    case (md)
      2'd1, 2'd2: begin
        for (int i = n - 1; i >= 1; i--) begin
          m_data[k][i]  = m_data[k][i-1];
          m_valid[k][i] = m_valid[k][i-1];
        end
        m_data[k][0]  = (md == 2'd1) ? d : last_d;
        m_valid[k][0] = (md == 2'd1) ? iv : last_v;
      end
      2'd3: for (int i = 0; i < n; i++) begin m_data[k][i] = d; m_valid[k][i] = iv; end
      default: ;
    endcase
  endfunction

  function automatic int model_count(int k);
    int c = 0;
    for (int i = 0; i < int'(depth_m[k]); i++) c += int'(m_valid[k][i]);
    return c;
  endfunction

  task automatic check_dut(input int k, input logic [31:0] dout, input bit ov, input int cnt,
                           input bit fu, input bit em, input logic [31:0] tout, input bit tv);
    int n = int'(depth_m[k]);
    int c = model_count(k);
    string p = (k == 0) ? "d8" : "d6";
    chk({p, "_data_out"}, dout, m_data[k][n-1]);
    chk({p, "_out_valid"}, ov, m_valid[k][n-1]);
    chk({p, "_count"}, cnt, c);
    chk({p, "_full"}, fu, c == n);
    chk({p, "_empty"}, em, c == 0);
    chk({p, "_tap_out"}, tout, (int'(tap_sel) < n) ? m_data[k][tap_sel] : 32'h0);
    chk({p, "_tap_valid"}, tv, (int'(tap_sel) < n) ? m_valid[k][tap_sel] : 1'b0);
  endtask

  task automatic check_all();
    check_dut(0, d8_out, d8_ov, int'(d8_cnt), d8_full, d8_empty, d8_tap, d8_tv);
    check_dut(1, d6_out, d6_ov, int'(d6_cnt), d6_full, d6_empty, d6_tap, d6_tv);
  endtask

  // Drive one cycle, advance the model on the same edge, check 1 time unit later.
  task automatic step(input bit r, input logic [1:0] md, input bit iv, input logic [31:0] d,
                      input logic [2:0] ts);
    rst = r; mode = md; in_valid = iv; data_in = d; tap_sel = ts;
    @(posedge clk);
    model_step(0, r, md, iv, d);
    model_step(1, r, md, iv, d);
    #1;
    check_all();
  endtask

  task automatic reset_arm();
    step(1, 2'd0, 0, 0, 0);
    step(0, 2'd0, 0, 0, 0);
  endtask

  initial begin
    // Reset and arm
    step(1, 2'd1, 1, 32'hA5A5A5A5, 0);
    step(1, 2'd1, 1, 32'hA5A5A5A5, 0);
    chk("rst_empty", d8_empty, 1'b1);
    chk("rst_data_out", d8_out, 32'h0);
    step(0, 2'd1, 1, 32'hA5A5A5A5, 0);
    chk("arm_ignored_count", d8_cnt, 4'd0);
    chk("arm_ignored_empty", d8_empty, 1'b1);
    step(0, 2'd1, 1, 32'hA5A5A5A5, 0);
    chk("arm_accept_count", d8_cnt, 4'd1);
    chk("arm_accept_tap", d8_tap, 32'hA5A5A5A5);

    // Delay line 1..12
    reset_arm();
    for (int v = 1; v <= 12; v++) begin
      step(0, 2'd1, 1, 32'(v), 3'd7);
      if (v == 7) chk("delay_not_yet", d8_ov, 1'b0);
      if (v == 8) begin
        chk("delay_data_out", d8_out, 32'd1);
        chk("delay_out_valid", d8_ov, 1'b1);
        chk("delay_full", d8_full, 1'b1);
      end
    end
    chk("delay_count_sat", d8_cnt, 4'd8);

    // Bubbles
    reset_arm();
    step(0, 2'd1, 1, 32'h11, 1);
    step(0, 2'd1, 0, 32'h22, 1);
    step(0, 2'd1, 1, 32'h33, 1);
    chk("bubble_count", d8_cnt, 4'd2);
    chk("bubble_tap_out", d8_tap, 32'h22);
    chk("bubble_tap_valid", d8_tv, 1'b0);

    // Rotate
    reset_arm();
    for (int v = 1; v <= 8; v++) step(0, 2'd1, 1, 32'(v), 0);
    step(0, 2'd2, 0, 32'hFFFF, 0);
    chk("rotate_stage0", d8_tap, 32'd1);
    for (int r = 0; r < 7; r++) step(0, 2'd2, 1, 32'hFFFF, 0);
    chk("rotate_back_stage0", d8_tap, 32'd8);
    chk("rotate_count", d8_cnt, 4'd8);

    // Fill / clear, with out-of-range tap on DEPTH=6
    step(0, 2'd3, 1, 32'hDEADBEEF, 0);
    chk("fill_count", d8_cnt, 4'd8);
    for (int t = 0; t < 8; t++) step(0, 2'd0, 0, 0, 3'(t));
    chk("tap7_d8", d8_tap, 32'hDEADBEEF);
    chk("tap7_d6_out", d6_tap, 32'h0);
    chk("tap7_d6_valid", d6_tv, 1'b0);
    chk("fill_d6_full", d6_full, 1'b1);
    step(0, 2'd3, 0, 32'h12345678, 0);
    chk("clear_empty", d8_empty, 1'b1);

    // Mid-run reset
    for (int v = 0; v < 5; v++) step(0, 2'd1, 1, $urandom, 0);
    step(1, 2'd1, 1, 32'hCAFE, 0);
    chk("midrst_count", d8_cnt, 4'd0);
    chk("midrst_tap", d8_tap, 32'h0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom), $urandom,
           3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_reg_chain.md
# shift_reg_chain

Parametrised multi-stage shift register: DEPTH stages of WIDTH bits, each stage carrying a valid bit. Four run-time modes: hold, shift, rotate, fill. Provides a registered end-of-chain output, a selectable tap, and occupancy tracking. It is the next-generation replacement for the single-stage enable-gated shift register, used as a configurable delay line and recirculating buffer in the datapath.

## Interface
Parameters:
- WIDTH, 32, data bits per stage (≥1)
- DEPTH, 8, number of stages (≥2)
- TAPW, $clog2(DEPTH), derived; do not override

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- mode  input  2  0 HOLD, 1 SHIFT, 2 ROTATE, 3 FILL
- in_valid  input  1  data_in qualifier
- data_in  input  WIDTH  word entering stage 0
- tap_sel  input  TAPW  stage index for tap_out
- data_out  output  WIDTH  stage[DEPTH-1] data, registered
- out_valid  output  1  stage[DEPTH-1] valid bit
- tap_out  output  WIDTH  stage[tap_sel] data; 0 if tap_sel ≥ DEPTH
- tap_valid  output  1  stage[tap_sel] valid; 0 if tap_sel ≥ DEPTH
- count  output  $clog2(DEPTH+1)  number of valid stages
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Internal arm flag: cleared by rst, set on the first clock edge without rst. While arm=0, every mode is treated as HOLD, so inputs are ignored for exactly one cycle after reset release.
- HOLD: no state change.
- SHIFT: stage[0] ← {in_valid, data_in}; stage[i] ← stage[i-1] for i ≥ 1.
  - The word in stage[DEPTH-1] is discarded.
  - count ← count + in_valid − out_valid.
- ROTATE: stage[0] ← stage[DEPTH-1]; stage[i] ← stage[i-1]. Valid bits rotate with their data. count is unchanged.
- FILL: every stage ← {in_valid, data_in}. count ← in_valid ? DEPTH : 0.
- Stage data is written even when in_valid=0; only the valid bit distinguishes bubbles.
- The count arithmetic is exact and never exceeds DEPTH.
  - SHIFT with full=1 and in_valid=1 keeps count at DEPTH (one in, one out).
  - SHIFT with empty=1 and in_valid=0 keeps count at 0.
- rst has priority over all modes. Reset mid-operation clears all data, valid bits, count and arm on that edge.

## Timing
- Reset values: data_out=0, out_valid=0, tap_out=0, tap_valid=0, count=0, full=0, empty=1. arm=0.
- All state updates occur on the clk rising edge.
- data_out, out_valid, count, full and empty come straight from registers.
- tap_out and tap_valid are a combinational mux of stage registers by tap_sel. They have zero added latency and no path from data_in.
- SHIFT latency: a word presented with in_valid on SHIFT cycle n reaches data_out after DEPTH consecutive SHIFT edges. It is visible after edge n+DEPTH-1 when SHIFT is continuous.
- The first edge after rst deasserts only sets arm. The first accepted operation is on the second edge.
- FILL: all stages are updated on one edge; data_out reflects data_in the cycle after.
- Mode changes take effect on the same edge; no pipeline flush is needed.

## Structure
- Package shift_reg_pkg holds:
  - mode constants MODE_HOLD/SHIFT/ROTATE/FILL (2-bit)
  - the stage struct {valid, data} parametrised by WIDTH, or the equivalent width localparams
- Sub-module shift_reg_stage: one data+valid register with a 2-input next-value select (previous stage or data_in) and load enable.
  - It is instantiated DEPTH times.
- Count, flags, arm and the tap mux stay in the top.

## Test plan
- Reset/arm: assert rst 2 cycles, then drive SHIFT with in_valid=1, data_in=0xA5A5A5A5 on the first cycle after release → word ignored; count stays 0, empty=1. On the next cycle it is accepted: count=1, tap_sel=0 gives tap_out=0xA5A5A5A5.
- Delay line: DEPTH=8, continuous SHIFT of 1,2,3,…,12 all valid → data_out=1 with out_valid=1 after the 8th accepted edge. Then count=8, full=1, and count stays 8 while shifting continues.
- Bubbles: SHIFT 0x11 valid, 0x22 invalid, 0x33 valid → count=2. When the invalid slot reaches tap_sel=1, tap_valid=0 while tap_out=0x22.
- Rotate: fill stages with 1..8 via SHIFT, then 8 ROTATE edges → state identical to before and count=8. After 1 ROTATE, stage[0]=1 (the previous stage[7]).
- Fill/clear: FILL with data_in=0xDEADBEEF, in_valid=1 → count=8, full=1, all taps = 0xDEADBEEF. FILL with in_valid=0 → count=0, empty=1.
- Mid-run reset plus out-of-range tap: assert rst during continuous SHIFT → all outputs return to reset values on the next edge. With non-power-of-2 DEPTH=6 and tap_sel=7, tap_out=0 and tap_valid=0.
